// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit.
// One ROM line carries four 32-bit instructions.
package fetch_pkg;
    localparam int INSTR_W = 32;
    localparam int LINE_W  = 128;
    localparam int SLOTS   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc;
    } iq_entry_t;
endpackage

// File: rtl/fetch_if.sv
// Fetch unit bus: ROM port, redirect input, dispatch handshake.
// master = fetch controller side, slave = environment side.
interface fetch_if #(
    parameter int QDEPTH = 8
);
    localparam int CW = $clog2(QDEPTH) + 1;

    logic [31:0]   rom_addr;
    logic [127:0]  rom_data;
    logic          jmp_valid;
    logic [31:0]   jmp_target;
    logic          iq_valid;
    logic [31:0]   iq_instr;
    logic [31:0]   iq_pc;
    logic          iq_ready;
    logic [CW-1:0] iq_count;

    modport master (
        input  rom_data, jmp_valid, jmp_target, iq_ready,
        output rom_addr, iq_valid, iq_instr, iq_pc, iq_count
    );

    modport slave (
        output rom_data, jmp_valid, jmp_target, iq_ready,
        input  rom_addr, iq_valid, iq_instr, iq_pc, iq_count
    );
endinterface

// File: rtl/fetch_ctrl_inst_queue.sv
// Instruction queue: circular buffer, 0..4 in-order pushes and one pop
// per cycle, synchronous clear. Head reads zero while empty.
module inst_queue
    import fetch_pkg::*;
#(
    parameter  int QDEPTH = 8,
    localparam int PW     = $clog2(QDEPTH),
    localparam int CW     = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic [2:0]    push_n_i,
    input  iq_entry_t     push_i [SLOTS],
    input  logic          pop_i,
    output iq_entry_t     head_o,
    output logic          valid_o,
    output logic [CW-1:0] count_o
);
    iq_entry_t     mem_q [QDEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q;
    logic          pop;

    assign valid_o = (cnt_q != '0);
    assign count_o = cnt_q;
    assign pop     = pop_i && valid_o;
    assign head_o  = valid_o ? mem_q[rd_q] : '0;

    always_ff @(posedge clk) begin
        for (int j = 0; j < SLOTS; j++) begin
            if (!clr_i && (3'(j) < push_n_i))
                mem_q[wr_q + PW'(j)] <= push_i[j];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (clr_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + PW'(push_n_i);
            rd_q  <= rd_q + PW'(pop);
            cnt_q <= cnt_q + CW'(push_n_i) - CW'(pop);
        end
    end
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: PC, FSM, line splitting and push sizing
// in front of the instruction queue.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int          QDEPTH   = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    output logic [1:0] fetch_state_o,
    fetch_if.master    bus
);
    localparam int CW = $clog2(QDEPTH) + 1;

    fetch_state_e  st_q, st_d;
    logic [31:0]   pc_q, pc_d;
    logic [1:0]    off;
    logic [2:0]    n_need, push_n;
    logic          clr;
    logic [CW-1:0] count, free;
    iq_entry_t     push_w [SLOTS];
    iq_entry_t     head;

    assign off    = pc_q[3:2];
    assign n_need = 3'(SLOTS) - {1'b0, off};
    // Push is sized against start-of-cycle occupancy; a same-cycle pop is not credited.
    assign free   = CW'(QDEPTH) - count;

    always_comb begin
        for (int j = 0; j < SLOTS; j++) begin
            push_w[j].instr = bus.rom_data[{off + 2'(j), 5'b0} +: 32];
            push_w[j].pc    = {pc_q[31:4], off + 2'(j), 2'b00};
        end
    end

    always_comb begin
        st_d   = st_q;
        pc_d   = pc_q;
        push_n = 3'd0;
        clr    = 1'b0;
        unique case (st_q)
            ST_IDLE: begin
                if (bus.jmp_valid)
                    pc_d = bus.jmp_target & 32'hFFFF_FFFC;
                else if (start_i)
                    st_d = ST_FETCH;
            end
            ST_FETCH, ST_FLUSH: begin
                if (bus.jmp_valid) begin
                    clr  = 1'b1;
                    pc_d = bus.jmp_target & 32'hFFFF_FFFC;
                    st_d = ST_FLUSH;
                end else if (st_q == ST_FLUSH) begin
                    st_d = ST_FETCH;
                end else if (free >= CW'(n_need)) begin
                    push_n = n_need;
                    pc_d   = (pc_q & 32'hFFFF_FFF0) + 32'h10;
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q <= ST_IDLE;
            pc_q <= RESET_PC & 32'hFFFF_FFFC;
        end else begin
            st_q <= st_d;
            pc_q <= pc_d;
        end
    end

    inst_queue #(.QDEPTH(QDEPTH)) u_iq (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (clr),
        .push_n_i (push_n),
        .push_i   (push_w),
        .pop_i    (bus.iq_ready),
        .head_o   (head),
        .valid_o  (bus.iq_valid),
        .count_o  (count)
    );

    assign bus.rom_addr = pc_q & 32'hFFFF_FFF0;
    assign bus.iq_instr = head.instr;
    assign bus.iq_pc    = head.pc;
    assign bus.iq_count = count;
    assign fetch_state_o = st_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: vector table, corner sequences,
// random traffic against a queue-based reference model.
module tb_fetch_ctrl;
    localparam int QDEPTH = 8;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ment_t;

    typedef struct {
        logic        start;
        logic        ready;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
        logic [31:0] exp_count;
        logic [31:0] exp_state;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic st0 = 1'b0, st1 = 1'b0;
    logic [1:0] fs0, fs1;

    int n_chk = 0;
    int n_fail = 0;

    ment_t       mq[$];
    int          mmode;
    logic [31:0] mpc;
    vec_t        vt[9];

    fetch_if #(.QDEPTH(QDEPTH)) f0 ();
    fetch_if #(.QDEPTH(QDEPTH)) f1 ();

    fetch_ctrl #(.QDEPTH(QDEPTH), .RESET_PC(32'h0)) dut0 (
        .clk(clk), .rst(rst), .start_i(st0),
        .fetch_state_o(fs0), .bus(f0.master)
    );
    fetch_ctrl #(.QDEPTH(QDEPTH), .RESET_PC(32'hFFFF_FFF0)) dut1 (
        .clk(clk), .rst(rst), .start_i(st1),
        .fetch_state_o(fs1), .bus(f1.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h100 + (a >> 2);
    endfunction

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            f0.rom_data[32*k +: 32] = rom_word(f0.rom_addr + 32'(4*k));
            f1.rom_data[32*k +: 32] = rom_word(f1.rom_addr + 32'(4*k));
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mmode = 0;
        mpc = 32'h0;
    endtask

    task automatic model_update(input logic s, input logic j,
                                input logic [31:0] t, input logic r);
        bit popped;
        int free, n;
        logic [31:0] line;
        popped = (mq.size() > 0) && r;
        free = QDEPTH - mq.size();
        line = mpc & 32'hFFFF_FFF0;
        if (mmode == 0) begin
            if (popped) mq.delete(0);
            if (j) mpc = {t[31:2], 2'b00};
            else if (s) mmode = 1;
        end else if (j) begin
            mq.delete();
            mpc = {t[31:2], 2'b00};
            mmode = 2;
        end else if (mmode == 2) begin
            mmode = 1;
        end else begin
            if (popped) mq.delete(0);
            n = 4 - int'(mpc[3:2]);
            if (free >= n) begin
                for (int k = int'(mpc[3:2]); k < 4; k++)
                    mq.push_back('{rom_word(line + 32'(4*k)), line + 32'(4*k)});
                mpc = line + 32'h10;
            end
        end
    endtask

    task automatic check_model();
        chk("m_valid", 32'(f0.iq_valid), 32'(mq.size() > 0));
        chk("m_count", 32'(f0.iq_count), 32'(mq.size()));
        chk("m_instr", f0.iq_instr, mq.size() > 0 ? mq[0].instr : 32'h0);
        chk("m_pc", f0.iq_pc, mq.size() > 0 ? mq[0].pc : 32'h0);
        chk("m_rom_addr", f0.rom_addr, mpc & 32'hFFFF_FFF0);
        chk("m_state", 32'(fs0), 32'(mmode));
    endtask

    task automatic step(input logic s, input logic j,
                        input logic [31:0] t, input logic r);
        st0 = s;
        f0.jmp_valid = j;
        f0.jmp_target = t;
        f0.iq_ready = r;
        @(posedge clk);
        model_update(s, j, t, r);
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        st0 = 1'b0;
        f0.jmp_valid = 1'b0;
        f0.iq_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        f0.jmp_valid = 1'b0; f0.jmp_target = '0; f0.iq_ready = 1'b0;
        f1.jmp_valid = 1'b0; f1.jmp_target = '0; f1.iq_ready = 1'b0;

        vt[0] = '{1'b1, 1'b1, 1'b0, 32'h0,   32'h00, 32'd0, 32'd1};
        vt[1] = '{1'b0, 1'b1, 1'b1, 32'h100, 32'h00, 32'd4, 32'd1};
        vt[2] = '{1'b0, 1'b1, 1'b1, 32'h101, 32'h04, 32'd7, 32'd1};
        vt[3] = '{1'b0, 1'b1, 1'b1, 32'h102, 32'h08, 32'd6, 32'd1};
        vt[4] = '{1'b0, 1'b1, 1'b1, 32'h103, 32'h0C, 32'd5, 32'd1};
        vt[5] = '{1'b0, 1'b1, 1'b1, 32'h104, 32'h10, 32'd4, 32'd1};
        vt[6] = '{1'b0, 1'b1, 1'b1, 32'h105, 32'h14, 32'd7, 32'd1};
        vt[7] = '{1'b0, 1'b1, 1'b1, 32'h106, 32'h18, 32'd6, 32'd1};
        vt[8] = '{1'b0, 1'b1, 1'b1, 32'h107, 32'h1C, 32'd5, 32'd1};

        do_reset();
        check_model();
        chk("reset_valid", 32'(f0.iq_valid), 32'd0);
        chk("reset_state", 32'(fs0), 32'd0);

        // In-order gapless stream from reset
        foreach (vt[i]) begin
            step(vt[i].start, 1'b0, 32'h0, vt[i].ready);
            chk("t1_valid", 32'(f0.iq_valid), 32'(vt[i].exp_valid));
            chk("t1_instr", f0.iq_instr, vt[i].exp_instr);
            chk("t1_pc", f0.iq_pc, vt[i].exp_pc);
            chk("t1_count", 32'(f0.iq_count), vt[i].exp_count);
            chk("t1_state", 32'(fs0), vt[i].exp_state);
        end

        // Backpressure: fill, stall, then drain until a full line fits
        do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t2_full_count", 32'(f0.iq_count), 32'd8);
        chk("t2_stall_addr", f0.rom_addr, 32'h20);
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("t2_drain_count", 32'(f0.iq_count), 32'd4);
        chk("t2_drain_addr", f0.rom_addr, 32'h20);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t2_refill_count", 32'(f0.iq_count), 32'd8);
        chk("t2_refill_addr", f0.rom_addr, 32'h30);
        chk("t2_head_pc", f0.iq_pc, 32'h10);

        // Redirect to a mid-line target
        do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h38, 1'b1);
        chk("t3_flush_valid", 32'(f0.iq_valid), 32'd0);
        chk("t3_flush_state", 32'(fs0), 32'd2);
        chk("t3_flush_addr", f0.rom_addr, 32'h30);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("t3_bubble_count", 32'(f0.iq_count), 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("t3_count", 32'(f0.iq_count), 32'd2);
        chk("t3_head_pc", f0.iq_pc, 32'h38);
        chk("t3_head_instr", f0.iq_instr, 32'h10E);
        chk("t3_next_addr", f0.rom_addr, 32'h40);

        // Redirect coinciding with a pop: popped head dropped
        step(1'b0, 1'b1, 32'h107, 1'b1);
        chk("t4_count", 32'(f0.iq_count), 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("t4_head_pc", f0.iq_pc, 32'h104);
        chk("t4_count_after", 32'(f0.iq_count), 32'd3);

        // Async reset during a stall with six entries
        do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h38, 1'b0);
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t5_stall_count", 32'(f0.iq_count), 32'd6);
        chk("t5_stall_addr", f0.rom_addr, 32'h50);
        rst = 1'b1;
        model_reset();
        #1;
        chk("t5_rst_valid", 32'(f0.iq_valid), 32'd0);
        chk("t5_rst_count", 32'(f0.iq_count), 32'd0);
        chk("t5_rst_state", 32'(fs0), 32'd0);
        chk("t5_rst_addr", f0.rom_addr, 32'h0);
        chk("t5_rst_instr", f0.iq_instr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t5_restart_pc", f0.iq_pc, 32'h0);
        chk("t5_restart_instr", f0.iq_instr, 32'h100);

        // Random traffic, including redirects while idle
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 10) == 0, ($urandom % 12) == 0,
                 $urandom & 32'h1FF, ($urandom % 3) != 0);
        end

        // PC wrap from the top line
        do_reset();
        st1 = 1'b1;
        @(negedge clk);
        st1 = 1'b0;
        chk("t6_state", 32'(fs1), 32'd1);
        chk("t6_addr_top", f1.rom_addr, 32'hFFFF_FFF0);
        @(negedge clk);
        chk("t6_addr_wrap", f1.rom_addr, 32'h0);
        chk("t6_count", 32'(f1.iq_count), 32'd4);
        chk("t6_head_pc", f1.iq_pc, 32'hFFFF_FFF0);
        chk("t6_head_instr", f1.iq_instr, rom_word(32'hFFFF_FFF0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
